// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared byte-wide memory port.
// The arbiter connects through the slave modport; stages and memory model use master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [15:0]       if_rdata;
    logic              if_done;

    logic              d_req;
    logic              d_wr;
    logic              d_word;
    logic [ADDR_W-1:0] d_addr;
    logic [15:0]       d_wdata;
    logic [15:0]       d_rdata;
    logic              d_done;

    logic              stall;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_wr, d_word, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done, stall,
        output mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_wr, d_word, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done, stall,
        input  mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide synchronous-read memory between instruction fetch and the
// MEM stage, splitting 16-bit accesses into byte accesses with data-first priority.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, DONE} state_t;

    state_t            state_q, state_d;
    logic              own_data_q, own_data_d;
    logic              wr_q, wr_d;
    logic              word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [15:0]       if_rdata_q, if_rdata_d;
    logic [15:0]       d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;

    logic              mem_re_c, mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [7:0]        mem_wdata_c;
    logic [15:0]       result_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            own_data_q <= 1'b0;
            wr_q       <= 1'b0;
            word_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            byte0_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            own_data_q <= own_data_d;
            wr_q       <= wr_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            byte0_q    <= byte0_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
        end
    end

    // byte0_q holds the byte at addr; the byte arriving now is the one at addr+1.
    always_comb begin
        if (!word_q) begin
            result_c = {8'h00, bus.mem_rdata};
        end else if (BIG_ENDIAN) begin
            result_c = {byte0_q, bus.mem_rdata};
        end else begin
            result_c = {bus.mem_rdata, byte0_q};
        end
    end

    always_comb begin
        state_d     = state_q;
        own_data_d  = own_data_q;
        wr_d        = wr_q;
        word_d      = word_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        byte0_d     = byte0_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        mem_re_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.d_req) begin
                    own_data_d = 1'b1;
                    addr_d     = bus.d_addr;
                    wr_d       = bus.d_wr;
                    word_d     = bus.d_word;
                    wdata_d    = bus.d_wdata;
                    state_d    = ACC0;
                end else if (bus.if_req) begin
                    own_data_d = 1'b0;
                    addr_d     = bus.if_addr;
                    wr_d       = 1'b0;
                    word_d     = 1'b1;
                    wdata_d    = '0;
                    state_d    = ACC0;
                end
            end
            ACC0: begin
                mem_addr_c = addr_q;
                if (wr_q) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = (word_q && BIG_ENDIAN) ? wdata_q[15:8] : wdata_q[7:0];
                    state_d     = word_q ? ACC1 : DONE;
                end else begin
                    mem_re_c = 1'b1;
                    state_d  = word_q ? ACC1 : CAP;
                end
            end
            ACC1: begin
                mem_addr_c = addr_q + ADDR_W'(1);
                if (wr_q) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = BIG_ENDIAN ? wdata_q[7:0] : wdata_q[15:8];
                    state_d     = DONE;
                end else begin
                    mem_re_c = 1'b1;
                    byte0_d  = bus.mem_rdata;
                    state_d  = CAP;
                end
            end
            CAP: begin
                if (own_data_q) begin
                    d_rdata_d = result_c;
                end else begin
                    if_rdata_d = result_c;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The done flop is loaded on entry so the pulse lines up with the DONE state.
        if (state_d == DONE) begin
            if (own_data_q) begin
                d_done_d = 1'b1;
            end else begin
                if_done_d = 1'b1;
            end
        end
    end

    // Reset gates the strobes directly so a reset mid-transaction cannot write memory.
    assign bus.mem_re    = mem_re_c & ~reset;
    assign bus.mem_we    = mem_we_c & ~reset;
    assign bus.mem_addr  = reset ? '0 : mem_addr_c;
    assign bus.mem_wdata = reset ? '0 : mem_wdata_c;

    assign bus.if_rdata = if_rdata_q;
    assign bus.if_done  = if_done_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_done   = d_done_q;
    assign bus.stall    = (bus.if_req & ~if_done_q) | (bus.d_req & ~d_done_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic on both ports.
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 16;
    localparam int WAIT_MAX = 40;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic reset_be = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus_be ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    mem_port_arbiter #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .reset(reset_be), .bus(bus_be));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Physical memories answering the DUTs, plus a backdoor preload path.
    logic [7:0]  phys    [0:65535];
    logic [7:0]  phys_be [0:65535];
    logic [7:0]  refm    [0:65535];
    logic        pl_we   = 1'b0;
    logic        pl_be   = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always @(posedge clk) begin
        if (bus.mem_re)    bus.mem_rdata <= phys[bus.mem_addr];
        if (bus.mem_we)    phys[bus.mem_addr] <= bus.mem_wdata;
        if (bus_be.mem_re) bus_be.mem_rdata <= phys_be[bus_be.mem_addr];
        if (bus_be.mem_we) phys_be[bus_be.mem_addr] <= bus_be.mem_wdata;
        if (pl_we && !pl_be) phys[pl_addr] <= pl_data;
        if (pl_we && pl_be)  phys_be[pl_addr] <= pl_data;
    end

    // Reference model: one transaction at a time, grant in a free cycle (data first),
    // byte ops at offsets 1..n after grant, done at the fixed latency for its kind.
    int          cyc = 0;
    int          m_g = 0;
    int          m_lat = 0;
    logic        m_busy = 1'b0;
    logic        m_own_d = 1'b0;
    logic        m_wr = 1'b0;
    logic        m_word = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] exp_if = '0;
    logic [15:0] exp_d = '0;

    always @(negedge clk) begin : model
        logic        e_re, e_we, e_ifd, e_dd;
        logic [15:0] e_addr, rv;
        logic [7:0]  e_wd;
        int          k;
        cyc++;
        if (pl_we && !pl_be) refm[pl_addr] = pl_data;
        e_re = 1'b0; e_we = 1'b0; e_ifd = 1'b0; e_dd = 1'b0;
        e_addr = '0; e_wd = '0; rv = '0;
        if (reset) begin
            chk("mem_re_in_reset", bus.mem_re, 1'b0);
            chk("mem_we_in_reset", bus.mem_we, 1'b0);
            m_busy = 1'b0;
            exp_if = '0;
            exp_d  = '0;
        end else begin
            if (m_busy && (cyc - m_g) > m_lat) m_busy = 1'b0;
            if (!m_busy && (bus.d_req || bus.if_req)) begin
                m_busy  = 1'b1;
                m_g     = cyc;
                m_own_d = bus.d_req;
                m_addr  = bus.d_req ? bus.d_addr : bus.if_addr;
                m_wr    = bus.d_req & bus.d_wr;
                m_word  = bus.d_req ? bus.d_word : 1'b1;
                m_wdata = bus.d_wdata;
                m_lat   = m_wr ? (m_word ? 3 : 2) : (m_word ? 4 : 3);
            end
            if (m_busy) begin
                k = cyc - m_g;
                if (k >= 1 && k <= (m_word ? 2 : 1)) begin
                    e_addr = m_addr + 16'(k - 1);
                    if (m_wr) begin
                        e_we = 1'b1;
                        e_wd = (k == 1) ? m_wdata[7:0] : m_wdata[15:8];
                        refm[e_addr] = e_wd;
                    end else begin
                        e_re = 1'b1;
                    end
                end
                if (k == m_lat) begin
                    if (!m_wr) begin
                        rv = m_word ? {refm[m_addr + 16'd1], refm[m_addr]} : {8'h00, refm[m_addr]};
                        if (m_own_d) exp_d = rv;
                        else         exp_if = rv;
                    end
                    if (m_own_d) e_dd = 1'b1;
                    else         e_ifd = 1'b1;
                end
            end
            chk("mem_re", bus.mem_re, e_re);
            chk("mem_we", bus.mem_we, e_we);
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wdata", bus.mem_wdata, e_wd);
            chk("if_done", bus.if_done, e_ifd);
            chk("d_done", bus.d_done, e_dd);
            chk("if_rdata", bus.if_rdata, exp_if);
            chk("d_rdata", bus.d_rdata, exp_d);
            chk("stall", bus.stall, (bus.if_req & ~e_ifd) | (bus.d_req & ~e_dd));
        end
    end

    // All driving tasks start and end just after a rising edge.
    task automatic pload(input logic be, input logic [15:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_be = be; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic i_access(input logic [15:0] a, output int lat, output logic [15:0] rd);
        int n = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        while (n < WAIT_MAX) begin
            @(negedge clk);
            if (bus.if_done) break;
            n++;
        end
        chk("if_done_seen", n < WAIT_MAX, 1'b1);
        lat = n;
        rd  = bus.if_rdata;
        @(posedge clk); #1;
        bus.if_req  = 1'b0;
        bus.if_addr = 16'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic d_access(input logic wr, input logic word, input logic [15:0] a,
                            input logic [15:0] wd, output int lat, output logic [15:0] rd);
        int n = 0;
        bus.d_req = 1'b1; bus.d_wr = wr; bus.d_word = word;
        bus.d_addr = a; bus.d_wdata = wd;
        while (n < WAIT_MAX) begin
            @(negedge clk);
            if (n == 1) bus.d_wdata = 16'($urandom);
            if (bus.d_done) break;
            n++;
        end
        chk("d_done_seen", n < WAIT_MAX, 1'b1);
        lat = n;
        rd  = bus.d_rdata;
        @(posedge clk); #1;
        bus.d_req  = 1'b0;
        bus.d_addr = 16'($urandom);
        bus.d_wr   = 1'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic be_wait(output int lat);
        int n = 0;
        while (n < WAIT_MAX) begin
            @(negedge clk);
            if (bus_be.if_done || bus_be.d_done) break;
            n++;
        end
        chk("be_done_seen", n < WAIT_MAX, 1'b1);
        lat = n;
    endtask

    function automatic logic [15:0] rand_addr();
        return 16'($urandom_range(0, 79)) - 16'd16;
    endfunction

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int          lat, lat_i;
        logic [15:0] rd, rd_i;
        {bus.if_req, bus.d_req, bus.d_wr, bus.d_word} = '0;
        bus.if_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
        {bus_be.if_req, bus_be.d_req, bus_be.d_wr, bus_be.d_word} = '0;
        bus_be.if_addr = '0; bus_be.d_addr = '0; bus_be.d_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; reset_be = 1'b0;
        @(negedge clk);
        chk("rst_if_rdata", bus.if_rdata, 16'h0);
        chk("rst_d_rdata", bus.d_rdata, 16'h0);
        chk("rst_done", {bus.if_done, bus.d_done}, 2'b00);
        @(posedge clk); #1;

        for (int a = -16; a <= 64; a++) pload(1'b0, 16'(a), 8'($urandom));
        pload(1'b0, 16'h0010, 8'h34); pload(1'b0, 16'h0011, 8'h12);
        pload(1'b0, 16'h0012, 8'h78); pload(1'b0, 16'h0013, 8'h56);
        pload(1'b0, 16'h0040, 8'hEF); pload(1'b0, 16'h0041, 8'hBE);
        pload(1'b0, 16'h0100, 8'h11); pload(1'b0, 16'h0101, 8'h22);

        i_access(16'h0010, lat, rd);
        chk("fetch_latency", lat, 4);
        chk("fetch_word", rd, 16'h1234);

        d_access(1'b1, 1'b0, 16'h0020, 16'hABCD, lat, rd);
        chk("bstore_latency", lat, 2);
        chk("bstore_byte", phys[16'h0020], 8'hCD);
        d_access(1'b0, 1'b0, 16'h0020, 16'h0000, lat, rd);
        chk("bload_latency", lat, 3);
        chk("bload_value", rd, 16'h00CD);

        d_access(1'b1, 1'b1, 16'hFFFF, 16'h5678, lat, rd);
        chk("wrap_latency", lat, 3);
        chk("wrap_lo", phys[16'hFFFF], 8'h78);
        chk("wrap_hi", phys[16'h0000], 8'h56);

        fork
            i_access(16'h0012, lat_i, rd_i);
            d_access(1'b0, 1'b1, 16'h0040, 16'h0000, lat, rd);
        join
        chk("contend_d_latency", lat, 4);
        chk("contend_d_word", rd, 16'hBEEF);
        chk("contend_i_latency", lat_i, 9);
        chk("contend_i_word", rd_i, 16'h5678);

        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_word = 1'b1;
        bus.d_addr = 16'h0100; bus.d_wdata = 16'h9A55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; bus.d_req = 1'b0;
        @(negedge clk);
        chk("abort_no_we", bus.mem_we, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_done", bus.d_done, 1'b0);
        chk("abort_d_rdata", bus.d_rdata, 16'h0);
        chk("abort_mem_addr", bus.mem_addr, 16'h0);
        chk("abort_first_byte", phys[16'h0100], 8'h55);
        chk("abort_second_byte", phys[16'h0101], 8'h22);
        @(posedge clk); #1;
        d_access(1'b0, 1'b1, 16'h0100, 16'h0000, lat, rd);
        chk("after_abort_latency", lat, 4);
        chk("after_abort_word", rd, 16'h2255);

        pload(1'b1, 16'h0010, 8'h12); pload(1'b1, 16'h0011, 8'h34);
        bus_be.if_req = 1'b1; bus_be.if_addr = 16'h0010;
        be_wait(lat);
        rd = bus_be.if_rdata;
        @(posedge clk); #1; bus_be.if_req = 1'b0; @(posedge clk); #1;
        chk("be_fetch_latency", lat, 4);
        chk("be_fetch_word", rd, 16'h1234);
        bus_be.d_req = 1'b1; bus_be.d_wr = 1'b1; bus_be.d_word = 1'b1;
        bus_be.d_addr = 16'h0020; bus_be.d_wdata = 16'hA1B2;
        be_wait(lat);
        @(posedge clk); #1; bus_be.d_req = 1'b0; @(posedge clk); #1;
        chk("be_store_latency", lat, 3);
        chk("be_store_first", phys_be[16'h0020], 8'hA1);
        chk("be_store_second", phys_be[16'h0021], 8'hB2);
        bus_be.d_req = 1'b1; bus_be.d_wr = 1'b0;
        be_wait(lat);
        rd = bus_be.d_rdata;
        @(posedge clk); #1; bus_be.d_req = 1'b0; @(posedge clk); #1;
        chk("be_load_word", rd, 16'hA1B2);

        fork
            begin
                int          l1;
                logic [15:0] r1;
                for (int n = 0; n < 80; n++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    i_access(rand_addr(), l1, r1);
                end
            end
            begin
                int          l2;
                logic [15:0] r2;
                for (int n = 0; n < 80; n++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    d_access(1'($urandom), 1'($urandom), rand_addr(), 16'($urandom), l2, r2);
                end
            end
        join

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one byte-wide, single-port, synchronous-read memory between instruction fetch (word reads) and the MEM stage (byte/word loads and stores).
- Splits each 16-bit access into sequenced byte accesses.
- Arbitrates when both requesters are pending and drives a pipeline stall until each request completes.
- Sits between the IF/MEM stages and the memory array.

Parameters:
ADDR_W, 16, address width of both requesters and the memory port
BIG_ENDIAN, 0, 0 = byte at addr is data[7:0]; 1 = byte at addr is data[15:8]

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high until if_done
if_addr  in  ADDR_W  fetch address, sampled at grant
if_rdata  out  16  fetched word, valid while if_done=1, held afterwards
if_done  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held high until d_done
d_wr  in  1  1 = store, 0 = load
d_word  in  1  1 = 16-bit access, 0 = 8-bit access
d_addr  in  ADDR_W  data address, sampled at grant
d_wdata  in  16  store data, sampled at grant; byte store uses [7:0]
d_rdata  out  16  load result; byte loads zero-extended; valid with d_done, held afterwards
d_done  out  1  one-cycle completion pulse for data
stall  out  1  (if_req & ~if_done) | (d_req & ~d_done), combinational
mem_addr  out  ADDR_W  memory byte address
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable
mem_wdata  out  8  memory write byte
mem_rdata  in  8  read byte, valid the cycle after mem_re

Behaviour:
- FSM states: IDLE, ACC0, ACC1, CAP, DONE.
- IDLE:
  - If d_req, grant D; else if if_req, grant I (fixed priority: data first).
  - At grant, latch owner, addr, wr, word and wdata; go to ACC0.
  - Fetch is always a word read.
- ACC0:
  - mem_addr = addr; first byte.
  - Read: mem_re=1.
  - Write: mem_we=1, mem_wdata = low byte (or high byte if BIG_ENDIAN).
  - Next state: word -> ACC1; byte read -> CAP; byte write -> DONE.
- ACC1:
  - mem_addr = addr+1, wrapping modulo 2^ADDR_W (0xFFFF -> 0x0000); second byte.
  - Read: mem_re=1 and capture mem_rdata as first byte; next CAP.
  - Write: mem_we=1 with the second byte; next DONE.
- CAP:
  - Capture mem_rdata into the final result: second byte (word) or low byte with upper byte 0 (byte load).
  - No memory op; next DONE.
- DONE:
  - Owner's done=1 for exactly one cycle; the owner's rdata register is updated at entry.
  - No memory op; next IDLE.
- Latency from grant cycle to done cycle: byte write 2, word write 3, byte read 3, word read 4.
- Minimum spacing between consecutive completions: one IDLE cycle.
- Requester rules:
  - Deassert req in the cycle after done.
  - Inputs may change after grant (already latched).
  - Dropping req before done does not abort the transaction; done still pulses.
- Simultaneous if_req and d_req in IDLE: D served first; I stays pending (stall=1) and is granted at the next IDLE.
- Idle outputs: mem_re=mem_we=0, mem_addr=0, mem_wdata=0 in IDLE, CAP and DONE.
- Reset:
  - State <= IDLE; if_done, d_done <= 0; if_rdata, d_rdata <= 0; all latched fields <= 0.
  - mem_we and mem_re are gated with ~reset combinationally, so no write occurs in the reset cycle even mid-transaction.
  - An aborted transaction produces no done.
- Read-data registers of the non-owner port are never disturbed.

Test Plan:
- Word fetch: memory [0x0010]=0x34, [0x0011]=0x12; if_req, if_addr=0x0010 -> if_done exactly 4 cycles after grant, if_rdata=0x1234, stall=1 until done.
- Byte load/store: d_wr=1, d_word=0, d_addr=0x0020, d_wdata=0xABCD -> one mem_we with addr 0x0020, data 0xCD; then byte load of 0x0020 -> d_rdata=0x00CD, d_done 3 cycles after grant.
- Word store at wrap: d_addr=0xFFFF, d_wdata=0x5678, word -> writes 0x78 at 0xFFFF then 0x56 at 0x0000; d_done 3 cycles after grant.
- Contention: if_req and d_req rise in the same cycle (word load of 0x0040 holding 0xBEEF) -> d_done first with d_rdata=0xBEEF, then if_done; if_rdata unchanged until its own done.
- Reset in ACC1 of a word store -> no mem_we in the reset cycle, no d_done, all outputs 0, FSM in IDLE next cycle; a new request is then served normally.
- BIG_ENDIAN=1, word fetch of bytes 0x12, 0x34 at 0x0010/0x0011 -> if_rdata=0x1234.
